// File: rtl/pi1_wrbuf.sv
// ============================================================================
// pi1_wrbuf : posted-write FIFO between a PI1 master port and its slave.
//   Optional read bypass of non-conflicting buffered writes: PI1WRBUF_RDFWD_EN
// Revision  : 1.0
// ============================================================================
`default_nettype none

module pi1_wrbuf #(
  parameter int  ARCHBITSZ = 16,
  parameter int  DEPTH     = 4,
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8),
  localparam int SELW      = ARCHBITSZ/8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           m_op_i,
  input  logic [ADDRBITSZ-1:0] m_addr_i,
  input  logic [ARCHBITSZ-1:0] m_data_i,
  output logic [ARCHBITSZ-1:0] m_data_o,
  input  logic [SELW-1:0]      m_sel_i,
  output logic                 m_rdy_o,
  output logic [1:0]           s_op_o,
  output logic [ADDRBITSZ-1:0] s_addr_o,
  output logic [ARCHBITSZ-1:0] s_data_o,
  input  logic [ARCHBITSZ-1:0] s_data_i,
  output logic [SELW-1:0]      s_sel_o,
  input  logic                 s_rdy_i
);

  localparam int         PTRW    = $clog2(DEPTH);
  localparam int         CNTW    = PTRW + 1;
  localparam logic [1:0] OP_NOOP = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDRBITSZ-1:0] fifo_addr_q [DEPTH];
  logic [ARCHBITSZ-1:0] fifo_data_q [DEPTH];
  logic [SELW-1:0]      fifo_sel_q  [DEPTH];
  logic [PTRW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]      cnt_q, cnt_d;

  logic [1:0]           hold_op_q;
  logic [ADDRBITSZ-1:0] hold_addr_q;
  logic [ARCHBITSZ-1:0] hold_data_q;
  logic [SELW-1:0]      hold_sel_q;
  logic [ARCHBITSZ-1:0] rdata_q;

  logic empty, full, drain_en, pop, push, m_acc, rd_acc, need_drain;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNTW'(DEPTH));
  assign drain_en = !rst_i && !empty && (state_q == S_IDLE || state_q == S_DRAIN);
  assign pop      = drain_en && s_rdy_i;
  // Full blocks the master even when a pop frees a slot this cycle.
  assign m_rdy_o  = !rst_i && (state_q == S_IDLE) && !full;
  assign m_acc    = m_rdy_o && (m_op_i != OP_NOOP);
  assign push     = m_acc && (m_op_i == OP_WR);
  assign rd_acc   = m_acc && m_op_i[1];
  assign cnt_d    = cnt_q + CNTW'(push) - CNTW'(pop);
  assign m_data_o = rdata_q;

`ifdef PI1WRBUF_RDFWD_EN
  logic [DEPTH-1:0] hit_vec;
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    logic [PTRW-1:0] offs;
    assign offs       = PTRW'(i) - rd_ptr_q;
    assign hit_vec[i] = ({1'b0, offs} < cnt_q) && (fifo_addr_q[i] == m_addr_i);
  end
  assign need_drain = |hit_vec;
`else
  assign need_drain = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    s_op_o   = OP_NOOP;
    s_addr_o = fifo_addr_q[rd_ptr_q];
    s_data_o = fifo_data_q[rd_ptr_q];
    s_sel_o  = fifo_sel_q[rd_ptr_q];
    if (drain_en) s_op_o = OP_WR;
    case (state_q)
      S_IDLE: begin
        if (rd_acc) begin
          if (need_drain && cnt_d != '0) state_d = S_DRAIN;
          else                           state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (empty || (pop && cnt_q == CNTW'(1))) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        s_op_o   = hold_op_q;
        s_addr_o = hold_addr_q;
        s_data_o = hold_data_q;
        s_sel_o  = hold_sel_q;
        if (s_rdy_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (s_rdy_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst_i) s_op_o = OP_NOOP;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      hold_op_q <= OP_NOOP;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push)   wr_ptr_q  <= wr_ptr_q + PTRW'(1);
      if (pop)    rd_ptr_q  <= rd_ptr_q + PTRW'(1);
      if (rd_acc) hold_op_q <= m_op_i;
      if (state_q == S_WAIT && s_rdy_i) rdata_q <= s_data_i;
    end
  end

  // Payload storage carries no reset; validity is tracked by cnt_q and hold_op_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= m_addr_i;
      fifo_data_q[wr_ptr_q] <= m_data_i;
      fifo_sel_q[wr_ptr_q]  <= m_sel_i;
    end
    if (rd_acc) begin
      hold_addr_q <= m_addr_i;
      hold_data_q <= m_data_i;
      hold_sel_q  <= m_sel_i;
    end
  end

endmodule

`default_nettype wire
